// File: rtl/pi_cbus_mch.sv
// pi_cbus_mch: cbus slave front end for the PI, NUM_CH DMA channels.
// Optional IO watchdog: define PI_CBUS_TIMEOUT_EN.
module pi_cbus_mch #(
    parameter int                NUM_CH      = 2,
    parameter int                CH_W        = 1,
    parameter int                ADDR_W      = 24,
    parameter int                LEN_W       = 16,
    parameter int                REG_AW      = 5,
    parameter int                RQ_DEPTH    = 4,
    parameter logic [3:0]        DEV_ID      = 4'h2,
    parameter logic [3:0]        PI_ID       = 4'h4,
    parameter logic [3:0]        BOOT_ID     = 4'h1,
    parameter logic [31:0]       PBUS_BASE   = 32'h0500_0000,
    parameter logic [REG_AW-1:0] IO_RD_REG   = REG_AW'(28),
    parameter logic [REG_AW-1:0] IO_WR_REG   = REG_AW'(29),
    parameter logic [7:0]        READ_DELAY  = 8'd2,
    parameter logic [7:0]        WRITE_DELAY = 8'hFF,
    parameter int                TIMEOUT     = 255
) (
    input  logic                     clock,
    input  logic                     reset_l,
    input  logic                     cbus_read_enable,
    input  logic                     cbus_write_enable,
    input  logic [1:0]               cbus_select,
    input  logic [2:0]               cbus_command,
    inout  wire  [31:0]              cbus_data,
    input  logic [CH_W-1:0]          dma_ch,
    input  logic [NUM_CH-1:0]        dma_read,
    input  logic [NUM_CH*ADDR_W-1:0] dma_address,
    input  logic [NUM_CH*LEN_W-1:0]  dma_length,
    input  logic [31:0]              reg_read_data,
    input  logic                     io_busy,
    output logic                     read_request,
    input  logic                     read_grant,
    output logic [31:0]              reg_write_data,
    output logic [REG_AW-1:0]        reg_address,
    output logic [REG_AW-1:0]        rd_address,
    output logic                     reg_write_enable,
    output logic [31:0]              io_address,
    output logic                     rq_overflow,
    output logic                     io_timeout
);

`ifdef PI_CBUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam int         PW     = $clog2(RQ_DEPTH);
    localparam logic [2:0] CMD_RD = 3'd1;
    localparam logic [2:0] CMD_WR = 3'd2;
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IO_IDLE,
        IO_SETTLE,
        IO_WAIT
    } io_state_t;

    // ---------------- capture path ----------------
    logic [31:0]       cd;
    logic [2:0]        cmd;
    logic [31:0]       out_mux;
    logic [CH_W-1:0]   ch;
    logic [ADDR_W-1:0] ch_addr;
    logic [LEN_W-1:0]  ch_len;
    logic              ch_rd;

    // Out-of-range channel numbers fall back to channel 0.
    assign ch      = (int'(dma_ch) < NUM_CH) ? dma_ch : '0;
    assign ch_addr = dma_address[int'(ch)*ADDR_W +: ADDR_W];
    assign ch_len  = dma_length[int'(ch)*LEN_W +: LEN_W];
    assign ch_rd   = dma_read[int'(ch)];

    // Word presented to the bus when the cbus is reading from us.
    always_comb begin
        out_mux = '0;
        case (cbus_select)
            2'd0: out_mux = 32'(ch_addr);
            2'd1: out_mux = {DEV_ID,
                             ch_rd ? READ_DELAY : WRITE_DELAY,
                             ch_rd,
                             19'(ch_len)};
            2'd2: out_mux = reg_read_data;
            default: out_mux = 'x;
        endcase
    end

    // Capture register: bus word on a read enable, else outgoing mux.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            cd  <= '0;
            cmd <= '0;
        end else begin
            cd  <= cbus_read_enable ? cbus_data : out_mux;
            cmd <= cbus_command;
        end
    end

    assign cbus_data      = cbus_write_enable ? cd : 'z;
    assign reg_write_data = cd;

    // ---------------- decode ----------------
    io_state_t         io_state;
    logic              settle;
    logic [7:0]        to_cnt;
    logic [3:0]        id;
    logic              pi_sel;
    logic              pbus_sel;
    logic              is_rd;
    logic              is_wr;
    logic              pi_wr;
    logic              pi_rd;
    logic              io_wr;
    logic              io_rd;
    logic              io_idle;
    logic              io_rd_ok;
    logic              io_rd_drop;
    logic [REG_AW-1:0] pi_addr;
    logic              to_hit;
    logic              io_done;

    assign id       = cd[31:28];
    assign pi_sel   = (id == PI_ID);
    assign pbus_sel = !pi_sel && (cd >= PBUS_BASE) && (id != BOOT_ID);
    assign is_rd    = (cmd == CMD_RD);
    assign is_wr    = (cmd == CMD_WR);
    assign pi_wr    = pi_sel && is_wr;
    assign pi_rd    = pi_sel && is_rd;
    assign io_wr    = pbus_sel && is_wr;
    assign io_rd    = pbus_sel && is_rd;
    assign pi_addr  = cd[REG_AW+1:2];

    assign io_idle    = (io_state == IO_IDLE);
    assign io_rd_ok   = io_rd && io_idle;
    assign io_rd_drop = io_rd && !io_idle;

    assign to_hit  = TO_EN && (io_state == IO_WAIT) && io_busy
                     && (to_cnt == TO_LIM);
    assign io_done = (io_state == IO_WAIT) && (!io_busy || to_hit);

    // Register-file write strobe and address for PI and PBUS accesses.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            reg_write_enable <= 1'b0;
            reg_address      <= '0;
            io_address       <= '0;
        end else begin
            reg_write_enable <= pi_wr || io_wr || io_rd_ok;
            unique case (1'b1)
                pi_wr: begin
                    reg_address <= pi_addr;
                end
                io_wr: begin
                    reg_address <= IO_WR_REG;
                    io_address  <= cd;
                end
                io_rd_ok: begin
                    reg_address <= IO_RD_REG;
                    io_address  <= cd;
                end
                default: ;
            endcase
        end
    end

    // PBUS read sequencer: two settle cycles, then wait for io_busy low.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            io_state   <= IO_IDLE;
            settle     <= 1'b0;
            to_cnt     <= '0;
            io_timeout <= 1'b0;
        end else begin
            io_timeout <= to_hit;
            if (io_state == IO_WAIT && !io_done)
                to_cnt <= to_cnt + 8'd1;
            else
                to_cnt <= '0;
            case (io_state)
                IO_IDLE: begin
                    if (io_rd_ok) begin
                        io_state <= IO_SETTLE;
                        settle   <= 1'b0;
                    end
                end
                IO_SETTLE: begin
                    if (settle)
                        io_state <= IO_WAIT;
                    else
                        settle <= 1'b1;
                end
                IO_WAIT: begin
                    if (io_done)
                        io_state <= IO_IDLE;
                end
                default: io_state <= IO_IDLE;
            endcase
        end
    end

    // ---------------- skid + response FIFO ----------------
    logic              skid_v;
    logic [REG_AW-1:0] skid_d;
    logic              skid_nv;
    logic [REG_AW-1:0] skid_nd;
    logic              skid_coll;
    logic              push_v;
    logic [REG_AW-1:0] push_d;
    logic              push_ok;
    logic              push_drop;
    logic              pop;
    logic              full;
    logic              empty;

    logic [REG_AW-1:0] mem [RQ_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;

    assign full  = (count == (PW+1)'(RQ_DEPTH));
    assign empty = (count == '0);
    assign pop   = read_grant && !empty;

    assign push_ok   = push_v && (!full || pop);
    assign push_drop = push_v && full && !pop;

    // One FIFO push per cycle: IO first, then a parked PI read, then a new one.
    always_comb begin
        push_v    = 1'b0;
        push_d    = '0;
        skid_nv   = skid_v;
        skid_nd   = skid_d;
        skid_coll = 1'b0;
        if (io_done) begin
            push_v = 1'b1;
            push_d = IO_RD_REG;
            if (pi_rd) begin
                if (skid_v) begin
                    skid_coll = 1'b1;
                end else begin
                    skid_nv = 1'b1;
                    skid_nd = pi_addr;
                end
            end
        end else if (skid_v) begin
            push_v  = 1'b1;
            push_d  = skid_d;
            skid_nv = pi_rd;
            if (pi_rd)
                skid_nd = pi_addr;
        end else if (pi_rd) begin
            push_v = 1'b1;
            push_d = pi_addr;
        end
    end

    // Skid register holding a PI read displaced by an IO completion.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            skid_v <= 1'b0;
            skid_d <= '0;
        end else begin
            skid_v <= skid_nv;
            skid_d <= skid_nd;
        end
    end

    // Response FIFO storage and pointers.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            for (int i = 0; i < RQ_DEPTH; i++)
                mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_d;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Sticky overflow: any lost response or rejected PBUS read.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l)
            rq_overflow <= 1'b0;
        else if (push_drop || io_rd_drop || skid_coll)
            rq_overflow <= 1'b1;
    end

    assign read_request = !empty;
    assign rd_address   = mem[rd_ptr];

endmodule

// File: tb/tb_pi_cbus_mch.sv
// tb_pi_cbus_mch: directed bench for pi_cbus_mch.
// Build with or without PI_CBUS_TIMEOUT_EN.
module tb_pi_cbus_mch;

`ifdef PI_CBUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_l;
    logic        cbus_read_enable;
    logic        cbus_write_enable;
    logic [1:0]  cbus_select;
    logic [2:0]  cbus_command;
    wire  [31:0] cbus_data;
    logic [31:0] drv;
    logic        drv_en;
    logic [0:0]  dma_ch;
    logic [1:0]  dma_read;
    logic [47:0] dma_address;
    logic [31:0] dma_length;
    logic [31:0] reg_read_data;
    logic        io_busy;
    logic        read_request;
    logic        read_grant;
    logic [31:0] reg_write_data;
    logic [4:0]  reg_address;
    logic [4:0]  rd_address;
    logic        reg_write_enable;
    logic [31:0] io_address;
    logic        rq_overflow;
    logic        io_timeout;

    int n_chk = 0;
    int n_err = 0;

    assign cbus_data = drv_en ? drv : 'z;

    always #5 clock = ~clock;

    pi_cbus_mch #(
        .TIMEOUT(10)
    ) dut (
        .clock            (clock),
        .reset_l          (reset_l),
        .cbus_read_enable (cbus_read_enable),
        .cbus_write_enable(cbus_write_enable),
        .cbus_select      (cbus_select),
        .cbus_command     (cbus_command),
        .cbus_data        (cbus_data),
        .dma_ch           (dma_ch),
        .dma_read         (dma_read),
        .dma_address      (dma_address),
        .dma_length       (dma_length),
        .reg_read_data    (reg_read_data),
        .io_busy          (io_busy),
        .read_request     (read_request),
        .read_grant       (read_grant),
        .reg_write_data   (reg_write_data),
        .reg_address      (reg_address),
        .rd_address       (rd_address),
        .reg_write_enable (reg_write_enable),
        .io_address       (io_address),
        .rq_overflow      (rq_overflow),
        .io_timeout       (io_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic drive(input logic [31:0] d, input logic [2:0] c);
        cbus_read_enable = 1'b1;
        drv_en           = 1'b1;
        drv              = d;
        cbus_command     = c;
    endtask

    task automatic idle();
        cbus_read_enable = 1'b0;
        drv_en           = 1'b0;
        cbus_command     = 3'd0;
    endtask

    task automatic do_reset();
        reset_l = 1'b0;
        #1;
        chk("rst_rr", read_request, 0);
        chk("rst_ovf", rq_overflow, 0);
        tick();
        reset_l = 1'b1;
        tick();
    endtask

    initial begin
        reset_l           = 1'b0;
        cbus_write_enable = 1'b0;
        cbus_select       = 2'd0;
        drv               = '0;
        dma_ch            = 1'b0;
        dma_read          = 2'b10;
        dma_address       = {24'h12_3456, 24'h00_1000};
        dma_length        = {16'h0100, 16'h0ABC};
        reg_read_data     = 32'hDEAD_BEEF;
        io_busy           = 1'b0;
        read_grant        = 1'b0;
        idle();
        tick();
        tick();
        chk("rst_rr", read_request, 0);
        chk("rst_we", reg_write_enable, 0);
        chk("rst_ovf", rq_overflow, 0);
        chk("rst_to", io_timeout, 0);
        chk("rst_ra", reg_address, 0);
        chk("rst_rd", rd_address, 0);
        chk("rst_ioa", io_address, 0);
        reset_l = 1'b1;
        tick();

        // PI write
        drive(32'h4000_0014, 3'd2);
        tick();
        idle();
        chk("piw_we_n", reg_write_enable, 0);
        tick();
        chk("piw_we", reg_write_enable, 1);
        chk("piw_ra", reg_address, 5);
        chk("piw_rr", read_request, 0);
        tick();
        chk("piw_we_off", reg_write_enable, 0);

        // Outgoing words
        cbus_write_enable = 1'b1;
        cbus_select       = 2'd1;
        dma_ch            = 1'b1;
        tick();
        chk("len_ch1", cbus_data, 32'h2028_0100);
        dma_ch = 1'b0;
        tick();
        chk("len_ch0", cbus_data, 32'h2FF0_0ABC);
        cbus_select = 2'd0;
        dma_ch      = 1'b1;
        tick();
        chk("addr_ch1", cbus_data, 32'h0012_3456);
        cbus_select = 2'd2;
        tick();
        chk("rdata", cbus_data, 32'hDEAD_BEEF);
        cbus_write_enable = 1'b0;
        cbus_select       = 2'd0;
        dma_ch            = 1'b0;
        tick();

        // PBUS read, io_busy high six cycles
        io_busy = 1'b1;
        drive(32'h0500_0010, 3'd1);
        tick();
        idle();
        tick();
        chk("pbr_we", reg_write_enable, 1);
        chk("pbr_ioa", io_address, 32'h0500_0010);
        chk("pbr_ra", reg_address, 28);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("pbr_wait_rr", read_request, 0);
        end
        io_busy = 1'b0;
        tick();
        chk("pbr_rr", read_request, 1);
        chk("pbr_rd", rd_address, 28);
        read_grant = 1'b1;
        tick();
        read_grant = 1'b0;
        chk("pbr_pop", read_request, 0);

        // PBUS read, earliest push at N+4
        drive(32'h0500_0010, 3'd1);
        tick();
        idle();
        tick();
        tick();
        tick();
        chk("pbe_n3", read_request, 0);
        tick();
        chk("pbe_n4", read_request, 1);
        read_grant = 1'b1;
        tick();
        read_grant = 1'b0;
        chk("pbe_pop", read_request, 0);

        // PBUS write
        drive(32'h0600_0000, 3'd2);
        tick();
        idle();
        tick();
        chk("pbw_we", reg_write_enable, 1);
        chk("pbw_ra", reg_address, 29);
        chk("pbw_ioa", io_address, 32'h0600_0000);

        // Boot space: no action
        drive(32'h1FC0_0000, 3'd1);
        tick();
        idle();
        tick();
        chk("boot_we", reg_write_enable, 0);
        tick();
        tick();
        tick();
        tick();
        chk("boot_rr", read_request, 0);
        chk("boot_ioa", io_address, 32'h0600_0000);

        // Grant on empty FIFO is ignored
        read_grant = 1'b1;
        tick();
        read_grant = 1'b0;
        chk("gr_empty", read_request, 0);
        chk("gr_empty_ovf", rq_overflow, 0);

        // PBUS read while sequencer busy is dropped
        io_busy = 1'b1;
        drive(32'h0500_0020, 3'd1);
        tick();
        idle();
        tick();
        drive(32'h0500_0030, 3'd1);
        tick();
        idle();
        tick();
        chk("drop_we", reg_write_enable, 0);
        chk("drop_ovf", rq_overflow, 1);
        chk("drop_ioa", io_address, 32'h0500_0020);
        do_reset();

        // Watchdog: WAIT entered at E3, fires ten edges later
        io_busy = 1'b1;
        drive(32'h0500_0010, 3'd1);
        tick();
        idle();
        tick();
        tick();
        tick();
        for (int k = 4; k <= 15; k++) begin
            tick();
            chk("wd_to", io_timeout, 32'(TO_EN && k == 13));
            chk("wd_rr", read_request, 32'(TO_EN && k >= 13));
        end
        io_busy = 1'b0;
        tick();
        chk("wd_release", read_request, 1);
        do_reset();

        // IO and PI push on the same edge, with a grant
        drive(32'h4000_001C, 3'd1);
        tick();
        drive(32'h0500_0010, 3'd1);
        tick();
        idle();
        tick();
        tick();
        drive(32'h4000_0024, 3'd1);
        tick();
        idle();
        chk("mix_head0", rd_address, 7);
        read_grant = 1'b1;
        tick();
        read_grant = 1'b0;
        chk("mix_rr", read_request, 1);
        chk("mix_head_io", rd_address, 28);
        tick();
        chk("mix_head_io2", rd_address, 28);
        read_grant = 1'b1;
        tick();
        chk("mix_head_pi", rd_address, 9);
        tick();
        read_grant = 1'b0;
        chk("mix_empty", read_request, 0);
        chk("mix_ovf", rq_overflow, 0);

        // Five back-to-back PI reads into a four-entry FIFO
        for (int a = 1; a <= 5; a++) begin
            drive(32'h4000_0000 | 32'(a << 2), 3'd1);
            tick();
        end
        idle();
        tick();
        chk("ovf_rr", read_request, 1);
        chk("ovf_head", rd_address, 1);
        chk("ovf_flag", rq_overflow, 1);
        for (int a = 1; a <= 4; a++) begin
            chk("ovf_order", rd_address, 32'(a));
            read_grant = 1'b1;
            tick();
            read_grant = 1'b0;
        end
        chk("ovf_drained", read_request, 0);
        chk("ovf_sticky", rq_overflow, 1);

        // Reset with entries pending empties the FIFO
        drive(32'h4000_0004, 3'd1);
        tick();
        idle();
        tick();
        chk("mid_rr", read_request, 1);
        do_reset();
        chk("post_rst_rr", read_request, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
